mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Pipeline stage directly downstream of the execute stage. Takes the ALU result (address or value),
//  the store data and the load/store control, and runs the data-memory handshake.
//  Performs byte/half/word lane steering plus load sign/zero extension, and delivers a registered
//  writeback packet to the WB stage. Raises stall_out to freeze upstream while a memory access is outstanding.
// PARAMETERS
//  XLEN    32  data/address width (only 32 supported; lane logic assumes 4 byte lanes)
//  REGW    5   destination register index width
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active-high
//  valid_in      in   1      EX result valid this cycle
//  alu_out       in   XLEN   ALU result: effective address for ld/st, else writeback value
//  store_data    in   XLEN   rs2 value for stores
//  mem_read      in   1      instruction is a load
//  mem_write     in   1      instruction is a store
//  funct3        in   3      000 B, 001 H, 010 W, 100 BU, 101 HU
//  rd_in         in   REGW   destination register
//  reg_write_in  in   1      instruction writes rd
//  stall_out     out  1      upstream must hold its current instruction
//  mem_req       out  1      memory request
//  mem_we        out  1      1 = write
//  mem_addr      out  XLEN   word-aligned address ({addr[31:2],2'b00})
//  mem_wdata     out  XLEN   store data replicated to the selected lanes
//  mem_be        out  4      byte enables
//  mem_ready     in   1      request accepted/completed this cycle (sampled only while mem_req=1)
//  mem_rdata     in   XLEN   read data, valid with mem_ready
//  valid_out     out  1      WB packet valid (one-cycle pulse per instruction)
//  wb_data       out  XLEN   writeback value
//  wb_rd         out  REGW   writeback register
//  wb_reg_write  out  1      writeback enable (0 for stores and dropped accesses)
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req, mem_we, mem_be, valid_out, wb_reg_write, stall_out = 0; data outs = 0.
//  - FSM IDLE/BUSY. stall_out = (state==BUSY), combinational from state.
//  - IDLE, valid_in, no mem op: capture alu_out/rd/reg_write into WB regs. valid_out=1 next cycle (latency 1).
//  - IDLE, valid_in, mem op, aligned: latch addr/ctrl/wdata/be and go to BUSY. mem_req=1 from the next cycle.
//  - mem_write has priority when mem_read and mem_write are both set (treated as a store).
//  - BUSY: mem_req, mem_we, mem_addr, mem_wdata and mem_be are held stable until mem_ready.
//    valid_in is ignored.
//  - mem_ready in BUSY: drop mem_req that edge and return to IDLE. valid_out=1 next cycle.
//    Loads: wb_data = lane-extracted, extended rdata; wb_reg_write = latched reg_write_in.
//    Stores: wb_reg_write = 0.
//  - Minimum mem latency: accept cycle N, req at N+1, ready at N+1 gives valid_out at N+2.
//    Each wait cycle adds 1.
//  - Lanes: B → be = 1<<addr[1:0], wdata = {4{sd[7:0]}}. H → be = addr[1]?1100:0011, wdata = {2{sd[15:0]}}.
//    W → be = 1111.
//  - Loads: B/H sign-extend, BU/HU zero-extend. Undefined funct3 = word.
//  - Alignment: H needs addr[0]=0; W needs addr[1:0]=0.
//    A misaligned access issues no mem_req; see CONFIGURATION.
//  - valid_out is a single-cycle pulse; no backpressure from WB.
//  - rst while BUSY: next edge forces IDLE and mem_req=0. The transaction is abandoned; no valid_out.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: adds outputs misalign_trap (1) and trap_addr (XLEN).
//    On a misaligned access: valid_out=1 next cycle, wb_reg_write=0, misaligned_trap=1, trap_addr = the address.
//    Both new outputs reset to 0.
//  MEM_MISALIGN_TRAP_EN undefined: no extra ports. A misaligned access is silently dropped:
//    valid_out=1 next cycle, wb_reg_write=0, no memory side effect.
// TESTING
//  1 ALU op alu_out=0x1234, rd=5, rw=1 -> next cycle valid_out=1, wb_data=0x1234, wb_rd=5; no mem_req.
//  2 LB addr=0x103, rdata=0x80FFFFFF, ready on first req cycle -> be=1000, wb_data=0xFFFFFF80,
//    valid_out 2 cycles after accept.
//  3 SH addr=0x202, sd=0xABCD, ready after 3 wait cycles -> be=1100, wdata=0xABCDABCD, stall_out high 4 cycles.
//    Signals stable; wb_reg_write=0.
//  4 LW addr=0x101 -> no mem_req, valid_out=1, wb_reg_write=0.
//    With macro: misalign_trap=1, trap_addr=0x101.
//  5 LHU addr=0x2, rdata=0xF00D0000 -> wb_data=0x0000F00D.
//  6 rst asserted during BUSY -> next cycle mem_req=0, stall_out=0, no valid_out; a following ALU op completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - data-memory access pipeline stage with lane steering and load extension
//
// Sits between EX and WB. An ALU result passes straight to the writeback
// registers one cycle later. A load or store is latched, held on the memory
// port until mem_ready, and its result is delivered as a one-cycle WB packet.
// stall_out freezes upstream while an access is outstanding.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   valid_in, alu_out, store_data,    EX result and load/store control
//   mem_read, mem_write, funct3,
//   rd_in, reg_write_in
//   stall_out                         upstream hold (high while BUSY)
//   mem_req, mem_we, mem_addr,        data-memory request side
//   mem_wdata, mem_be
//   mem_ready, mem_rdata              data-memory response side
//   valid_out, wb_data, wb_rd,        registered writeback packet
//   wb_reg_write
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   Adds misalign_trap / trap_addr, pulsed with valid_out on a misaligned access.
//   Without it a misaligned access is dropped (valid_out with wb_reg_write=0).

module mem_access_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [REGW-1:0] rd_in,
  input  logic            reg_write_in,
  output logic            stall_out,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            valid_out,
  output logic [XLEN-1:0] wb_data,
  output logic [REGW-1:0] wb_rd,
  output logic            wb_reg_write
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_addr
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [REGW-1:0] wb_rd_q, wb_rd_d;
  logic            wb_rw_q, wb_rw_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;

  logic            is_mem;
  logic            misaligned;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_val;

  assign is_mem = mem_read | mem_write;

  // Lane selection for the incoming access; funct3[1:0] picks the size,
  // and any encoding other than B/H is treated as a word.
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_out[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        misaligned = alu_out[0];
        be_new     = alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{store_data[15:0]}};
      end
      default: begin
        misaligned = |alu_out[1:0];
      end
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend; funct3[2] = unsigned.
  assign rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q[1:0])
      2'b00:   load_val = {{24{rdata_shifted[7] & ~f3_q[2]}}, rdata_shifted[7:0]};
      2'b01:   load_val = {{16{rdata_shifted[15] & ~f3_q[2]}}, rdata_shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    we_d        = we_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    valid_d     = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    trap_d      = 1'b0;
    trap_addr_d = trap_addr_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!is_mem) begin
            valid_d   = 1'b1;
            wb_data_d = alu_out;
            wb_rd_d   = rd_in;
            wb_rw_d   = reg_write_in;
          end else if (misaligned) begin
            // No memory side effect; retire with writeback suppressed.
            valid_d     = 1'b1;
            wb_data_d   = alu_out;
            wb_rd_d     = rd_in;
            wb_rw_d     = 1'b0;
            trap_d      = 1'b1;
            trap_addr_d = alu_out;
          end else begin
            state_d = BUSY;
            addr_d  = alu_out;
            wdata_d = wdata_new;
            be_d    = be_new;
            we_d    = mem_write;  // store wins when both read and write are set
            f3_d    = funct3;
            rd_d    = rd_in;
            rw_d    = reg_write_in;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d   = IDLE;
          valid_d   = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = we_q ? addr_q : load_val;
          wb_rw_d   = we_q ? 1'b0 : rw_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      valid_q     <= valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign stall_out    = (state_q == BUSY);
  assign mem_req      = stall_out;
  assign mem_we       = stall_out & we_q;
  assign mem_be       = stall_out ? be_q : 4'b0000;
  assign mem_addr     = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata    = wdata_q;
  assign valid_out    = valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_rw_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign trap_addr     = trap_addr_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] trap_addr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_out(alu_out),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .valid_out(valid_out),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .trap_addr(trap_addr)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; alu_out = 0; store_data = 0; mem_read = 0; mem_write = 0;
    funct3 = 0; rd_in = 0; reg_write_in = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid_out); end
    n_cmp++; if ({mem_we, mem_be, wb_reg_write} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl got %b want 000000", {mem_we, mem_be, wb_reg_write}); end
    n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL reset_wb_data got %h want 00000000", wb_data); end
    rst = 0;
    step();
  endtask

  task automatic test_alu();
    valid_in = 1; alu_out = 32'h1234; rd_in = 5; reg_write_in = 1;
    step();
    idle_inputs();
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL alu_valid got %0b want 1", valid_out); end
    n_cmp++; if (wb_data !== 32'h1234) begin n_bad++; $display("FAIL alu_wb_data got %h want 00001234", wb_data); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_bad++; $display("FAIL alu_wb_rd got %0d want 5", wb_rd); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_bad++; $display("FAIL alu_wb_rw got %0b want 1", wb_reg_write); end
    n_cmp++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL alu_no_req got req=%0b stall=%0b want 0/0", mem_req, stall_out); end
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL alu_pulse got %0b want 0", valid_out); end
  endtask

  task automatic test_lb();
    valid_in = 1; mem_read = 1; funct3 = 3'b000; alu_out = 32'h103; rd_in = 7; reg_write_in = 1;
    step();
    idle_inputs();
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL lb_req got req=%0b we=%0b want 1/0", mem_req, mem_we); end
    n_cmp++; if (mem_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got %b want 1000", mem_be); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL lb_addr got %h want 00000100", mem_addr); end
    n_cmp++; if (valid_out !== 1'b0 || stall_out !== 1'b1) begin n_bad++; $display("FAIL lb_busy got valid=%0b stall=%0b want 0/1", valid_out, stall_out); end
    mem_ready = 1; mem_rdata = 32'h80FFFFFF;
    step();
    mem_ready = 0; mem_rdata = 0;
    n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL lb_valid got %0b want 1", valid_out); end
    n_cmp++; if (wb_data !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_wb_data got %h want ffffff80", wb_data); end
    n_cmp++; if (wb_rd !== 5'd7 || wb_reg_write !== 1'b1) begin n_bad++; $display("FAIL lb_wb_rd got rd=%0d rw=%0b want 7/1", wb_rd, wb_reg_write); end
    n_cmp++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL lb_release got req=%0b stall=%0b want 0/0", mem_req, stall_out); end
  endtask

  task automatic test_sh_wait();
    int stalls = 0;
    int bad_hold = 0;
    valid_in = 1; mem_write = 1; funct3 = 3'b001; alu_out = 32'h202; store_data = 32'h5555ABCD; rd_in = 9; reg_write_in = 1;
    step();
    // A second instruction presented while BUSY must be ignored.
    mem_write = 0; alu_out = 32'h999; rd_in = 1;
    for (int i = 0; i < 4; i++) begin
      if (stall_out) stalls++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
          mem_wdata !== 32'hABCDABCD || mem_be !== 4'b1100) bad_hold++;
      mem_ready = (i == 3);
      step();
    end
    idle_inputs();
    n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL sh_hold got %0d unstable cycles want 0 (last req=%0b we=%0b addr=%h wdata=%h be=%b)", bad_hold, mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
    n_cmp++; if (stalls != 4) begin n_bad++; $display("FAIL sh_stall_cycles got %0d want 4", stalls); end
    n_cmp++; if (valid_out !== 1'b1 || wb_reg_write !== 1'b0) begin n_bad++; $display("FAIL sh_wb got valid=%0b rw=%0b want 1/0", valid_out, wb_reg_write); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL sh_release got %0b want 0", stall_out); end
    step();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL sh_ignored_valid_in got valid=%0b want 0", valid_out); end
  endtask

  task automatic test_store_priority();
    valid_in = 1; mem_read = 1; mem_write = 1; funct3 = 3'b000; alu_out = 32'h301; store_data = 32'h1234565A; rd_in = 4; reg_write_in = 1;
    step();
    idle_inputs();
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL prio_we got %0b want 1", mem_we); end
    n_cmp++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL prio_lanes got be=%b wdata=%h want 0010/5a5a5a5a", mem_be, mem_wdata); end
    mem_ready = 1;
    step();
    mem_ready = 0;
    n_cmp++; if (valid_out !== 1'b1 || wb_reg_write !== 1'b0) begin n_bad++; $display("FAIL prio_wb got valid=%0b rw=%0b want 1/0", valid_out, wb_reg_write); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2] = '{32'h101, 32'h3};
    logic [2:0]  f3s   [2] = '{3'b010, 3'b001};
    for (int i = 0; i < 2; i++) begin
      valid_in = 1; mem_read = 1; funct3 = f3s[i]; alu_out = addrs[i]; rd_in = 6; reg_write_in = 1;
      step();
      idle_inputs();
      n_cmp++; if (valid_out !== 1'b1 || wb_reg_write !== 1'b0) begin n_bad++; $display("FAIL misalign_wb[%0d] got valid=%0b rw=%0b want 1/0", i, valid_out, wb_reg_write); end
      n_cmp++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL misalign_req[%0d] got req=%0b stall=%0b want 0/0", i, mem_req, stall_out); end
`ifdef MEM_MISALIGN_TRAP_EN
      n_cmp++; if (misalign_trap !== 1'b1 || trap_addr !== addrs[i]) begin n_bad++; $display("FAIL misalign_trap[%0d] got %0b/%h want 1/%h", i, misalign_trap, trap_addr, addrs[i]); end
`endif
      step();
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL misalign_late_req[%0d] got %0b want 0", i, mem_req); end
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [4] = '{32'h2, 32'h0, 32'h4, 32'h1};
    logic [2:0]  f3s   [4] = '{3'b101, 3'b001, 3'b010, 3'b100};
    logic [31:0] rds   [4] = '{32'hF00D0000, 32'h00008001, 32'hDEADBEEF, 32'h0000F000};
    logic [31:0] exps  [4] = '{32'h0000F00D, 32'hFFFF8001, 32'hDEADBEEF, 32'h000000F0};
    for (int i = 0; i < 4; i++) begin
      valid_in = 1; mem_read = 1; funct3 = f3s[i]; alu_out = addrs[i]; rd_in = 5'(10 + i); reg_write_in = 1;
      step();
      idle_inputs();
      mem_ready = 1; mem_rdata = rds[i];
      step();
      mem_ready = 0; mem_rdata = 0;
      n_cmp++; if (valid_out !== 1'b1 || wb_data !== exps[i]) begin n_bad++; $display("FAIL load_ext[%0d] got valid=%0b data=%h want 1/%h", i, valid_out, wb_data, exps[i]); end
    end
  endtask

  task automatic test_reset_busy();
    int seen_valid = 0;
    valid_in = 1; mem_read = 1; funct3 = 3'b010; alu_out = 32'h40; rd_in = 2; reg_write_in = 1;
    step();
    idle_inputs();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstbusy_pre got req=%0b want 1", mem_req); end
    rst = 1;
    step();
    rst = 0;
    n_cmp++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin n_bad++; $display("FAIL rstbusy_idle got req=%0b stall=%0b want 0/0", mem_req, stall_out); end
    mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      if (valid_out) seen_valid++;
      step();
    end
    mem_ready = 0; mem_rdata = 0;
    n_cmp++; if (seen_valid != 0) begin n_bad++; $display("FAIL rstbusy_no_valid got %0d pulses want 0", seen_valid); end
    valid_in = 1; alu_out = 32'h77; rd_in = 3; reg_write_in = 1;
    step();
    idle_inputs();
    n_cmp++; if (valid_out !== 1'b1 || wb_data !== 32'h77 || wb_rd !== 5'd3) begin n_bad++; $display("FAIL rstbusy_after got valid=%0b data=%h rd=%0d want 1/00000077/3", valid_out, wb_data, wb_rd); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    test_reset();
    test_alu();
    test_lb();
    test_sh_wait();
    test_store_priority();
    test_misalign();
    test_load_ext();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
